// File: rtl/dna_llr_pkg.sv
// Shared types, default widths and the saturating add used by every
// accumulator lane of the LLR read combiner.
package dna_llr_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LLR_W      = 32;
  localparam int DEF_ACC_W      = 40;
  localparam int DEF_MAX_READS  = 16;

  // Working width of sat_add; lanes sign-extend into it, so ACC_W and LLR_W must stay below it.
  localparam int SAT_W = 64;

  localparam logic signed [31:0] LLR_ONE = 32'sd1 <<< 23;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  typedef logic signed [SAT_W:0] wide_t;

  typedef struct packed {
    logic signed [SAT_W-1:0] sum;
    logic                    sat;
  } sat_res_t;

  // Signed add clamped symmetrically to +/-(2^(w-1)-1); sat flags any clamp.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned             w);
    wide_t    s;
    wide_t    lim;
    sat_res_t r;
    s     = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    lim   = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    r.sum = s[SAT_W-1:0];
    r.sat = 1'b0;
    if (s > lim) begin
      r.sum = lim[SAT_W-1:0];
      r.sat = 1'b1;
    end else if (s < -lim) begin
      r.sum = -lim[SAT_W-1:0];
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/llr_sat_acc.sv
// One bit-position lane: signed saturating accumulator with clear, enable and
// position mask. Exposes its next value so the top can register outputs on HOLD entry.
module llr_sat_acc
  import dna_llr_pkg::*;
#(
  parameter int LLR_W = DEF_LLR_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic             active,
  input  logic [LLR_W-1:0] llr,
  output logic [ACC_W-1:0] acc_nxt,
  output logic             sat
);

  logic [ACC_W-1:0]       acc_q, acc_d;
  sat_res_t               res;
  logic [SAT_W-1:ACC_W]   sum_hi_unused;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d         = acc_q;
    sat           = 1'b0;
    res           = sat_add({{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                            {{(SAT_W-LLR_W){llr[LLR_W-1]}}, llr}, ACC_W);
    sum_hi_unused = res.sum[SAT_W-1:ACC_W];
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      if (active) begin
        acc_d = res.sum[ACC_W-1:0];
        sat   = res.sat;
      end else begin
        acc_d = '0;
      end
    end
  end

  assign acc_nxt = acc_d;

  // NOTE: the accumulator is real per-lane state observed after reset, so it sits on the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/llr_read_combiner.sv
// Accumulates soft values over several decoded reads of one cluster and emits a
// consensus codeword with erasure mask over a valid/ready handshake.
module llr_read_combiner
  import dna_llr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LLR_W      = DEF_LLR_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int MAX_READS  = DEF_MAX_READS,
  localparam int RW        = $clog2(MAX_READS + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [RW-1:0]                    num_reads_in,
  input  logic signed [31:0]               N_in,
  input  logic                             flush,
  input  logic                             llr_valid,
  input  logic [DATA_WIDTH-1:0][LLR_W-1:0] llr_in,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_bits,
  output logic [DATA_WIDTH-1:0]            out_erasure,
  output logic [RW-1:0]                    out_reads,
  output logic                             err_drop,
  output logic                             err_sat
);

  state_e                 state_q, state_d;
  logic [RW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0]          num_reads_q, num_reads_d;
  logic signed [31:0]     n_q, n_d;
  logic                   err_drop_q, err_drop_d, err_sat_q, err_sat_d;
  logic                   out_valid_q, out_valid_d, busy_q, busy_d;
  logic [DATA_WIDTH-1:0]  out_bits_q, out_bits_d, out_erasure_q, out_erasure_d;
  logic [RW-1:0]          out_reads_q, out_reads_d;

  logic                   start_ok, lane_clear, lane_en;
  logic [DATA_WIDTH-1:0]  lane_active, lane_sat;
  logic [ACC_W-1:0]       acc_nxt [DATA_WIDTH];

  assign start_ok   = start && (num_reads_in != '0) && (num_reads_in <= RW'(MAX_READS));
  assign lane_clear = start_ok && (state_q != HOLD);
  assign lane_en    = (state_q == ACCUM) && llr_valid && !start_ok;
  assign cnt_inc    = cnt_q + RW'(1);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    localparam logic signed [31:0] IDX = i;
    assign lane_active[i] = (n_q > IDX);
    llr_sat_acc #(.LLR_W(LLR_W), .ACC_W(ACC_W)) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (lane_clear),
      .en      (lane_en),
      .active  (lane_active[i]),
      .llr     (llr_in[i]),
      .acc_nxt (acc_nxt[i]),
      .sat     (lane_sat[i])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_ok) state_d = ACCUM;
      ACCUM: begin
        if (start_ok)                                 state_d = ACCUM;
        else if (llr_valid && cnt_inc == num_reads_q) state_d = HOLD;
        else if (flush) state_d = (llr_valid || cnt_q != '0) ? HOLD : IDLE;
      end
      HOLD:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    num_reads_d   = num_reads_q;
    n_d           = n_q;
    err_sat_d     = err_sat_q | (lane_en & (|lane_sat));
    err_drop_d    = err_drop_q | (llr_valid && state_q != ACCUM);
    out_bits_d    = out_bits_q;
    out_erasure_d = out_erasure_q;
    out_reads_d   = out_reads_q;
    if (lane_clear) begin
      cnt_d       = '0;
      num_reads_d = num_reads_in;
      n_d         = N_in;
      err_sat_d   = 1'b0;
      // A read coinciding with an accepted start is dropped and still reported.
      err_drop_d  = llr_valid;
    end else if (lane_en) begin
      cnt_d = cnt_inc;
    end
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
    if (state_q == ACCUM && state_d == HOLD) begin
      out_reads_d = cnt_d;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        out_bits_d[i]    = lane_active[i] & acc_nxt[i][ACC_W-1];
        out_erasure_d[i] = lane_active[i] & (acc_nxt[i] == '0);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      num_reads_q   <= '0;
      n_q           <= '0;
      err_drop_q    <= 1'b0;
      err_sat_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      out_bits_q    <= '0;
      out_erasure_q <= '0;
      out_reads_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      num_reads_q   <= num_reads_d;
      n_q           <= n_d;
      err_drop_q    <= err_drop_d;
      err_sat_q     <= err_sat_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      out_bits_q    <= out_bits_d;
      out_erasure_q <= out_erasure_d;
      out_reads_q   <= out_reads_d;
    end
  end

  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign out_bits    = out_bits_q;
  assign out_erasure = out_erasure_q;
  assign out_reads   = out_reads_q;
  assign err_drop    = err_drop_q;
  assign err_sat     = err_sat_q;

endmodule

// File: tb/tb_llr_read_combiner.sv
// Directed bench for llr_read_combiner: default instance plus a narrow-accumulator
// instance (ACC_W=34) sharing the same stimulus for the saturation case.
module tb_llr_read_combiner;
  import dna_llr_pkg::*;

  typedef logic [31:0][31:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush, llr_valid, out_ready;
  logic [4:0]  num_reads_in;
  logic signed [31:0] N_in;
  vec_t        llr_in;

  logic        busy, out_valid, err_drop, err_sat;
  logic [31:0] out_bits, out_erasure;
  logic [4:0]  out_reads;
  logic        busy_s, out_valid_s, err_drop_s, err_sat_s;
  logic [31:0] out_bits_s, out_erasure_s;
  logic [4:0]  out_reads_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  llr_read_combiner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_reads_in(num_reads_in), .N_in(N_in),
    .flush(flush), .llr_valid(llr_valid), .llr_in(llr_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_erasure(out_erasure), .out_reads(out_reads), .err_drop(err_drop), .err_sat(err_sat)
  );

  llr_read_combiner #(.ACC_W(34)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .num_reads_in(num_reads_in), .N_in(N_in),
    .flush(flush), .llr_valid(llr_valid), .llr_in(llr_in), .busy(busy_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_bits(out_bits_s),
    .out_erasure(out_erasure_s), .out_reads(out_reads_s), .err_drop(err_drop_s),
    .err_sat(err_sat_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t sign_vec(input logic [31:0] neg);
    vec_t v;
    for (int i = 0; i < 32; i++) v[i] = neg[i] ? -LLR_ONE : LLR_ONE;
    return v;
  endfunction

  task automatic do_start(input int nr, input int n);
    start        = 1'b1;
    num_reads_in = 5'(nr);
    N_in         = n;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic fl);
    llr_valid = 1'b1;
    llr_in    = v;
    flush     = fl;
    @(negedge clk);
    llr_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] bits,
                           input logic [31:0] era, input int reads);
    check({tag, "_valid"},   64'(out_valid),   64'd1);
    check({tag, "_bits"},    64'(out_bits),    64'(bits));
    check({tag, "_erasure"}, 64'(out_erasure), 64'(era));
    check({tag, "_reads"},   64'(out_reads),   64'(reads));
  endtask

  initial begin
    vec_t vmax;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; llr_valid = 1'b0; out_ready = 1'b0;
    num_reads_in = '0; N_in = 0; llr_in = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_bits",  64'(out_bits), 64'd0);
    check("rst_era",   64'(out_erasure), 64'd0);
    check("rst_reads", 64'(out_reads), 64'd0);
    check("rst_errs",  64'({err_drop, err_sat}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Alternating signs, 3 reads over 8 positions.
    do_start(3, 8);
    check("t1_busy", 64'(busy), 64'd1);
    send(sign_vec(32'h5555_5555), 1'b0);
    send(sign_vec(32'h5555_5555), 1'b0);
    check("t1_early_valid", 64'(out_valid), 64'd0);
    send(sign_vec(32'h5555_5555), 1'b0);
    check_out("t1", 32'h55, 32'h0, 3);
    check("t1_errs", 64'({err_drop, err_sat}), 64'd0);
    accept();
    check("t1_idle_valid", 64'(out_valid), 64'd0);
    check("t1_idle_busy",  64'(busy), 64'd0);

    // Majority vote: bit0 -,-,+ ; bit1 +,+,-.
    do_start(3, 4);
    send(sign_vec(32'h1), 1'b0);
    send(sign_vec(32'h1), 1'b0);
    send(sign_vec(32'h2), 1'b0);
    check_out("t2", 32'h1, 32'h0, 3);
    accept();

    // Tie on bit0 gives an erasure.
    do_start(2, 4);
    send(sign_vec(32'h0), 1'b0);
    send(sign_vec(32'h1), 1'b0);
    check_out("t3", 32'h0, 32'h1, 2);
    accept();

    // 16 reads of max positive: narrow instance clamps, wide one does not.
    for (int i = 0; i < 32; i++) vmax[i] = 32'h7FFF_FFFF;
    do_start(16, 32);
    for (int r = 0; r < 16; r++) send(vmax, 1'b0);
    check("t4s_valid", 64'(out_valid_s), 64'd1);
    check("t4s_sat",   64'(err_sat_s), 64'd1);
    check("t4s_bits",  64'(out_bits_s), 64'd0);
    check("t4s_era",   64'(out_erasure_s), 64'd0);
    check("t4s_reads", 64'(out_reads_s), 64'd16);
    check("t4w_sat",   64'(err_sat), 64'd0);
    check("t4w_bits",  64'(out_bits), 64'd0);
    accept();
    do_start(1, 8);
    check("t4s_sat_cleared", 64'(err_sat_s), 64'd0);
    send(sign_vec(32'h0), 1'b0);
    accept();

    // Masking at N=5, N=0 and N beyond the width.
    do_start(1, 5);
    send(sign_vec(32'hFFFF_FFFF), 1'b0);
    check_out("t5", 32'h1F, 32'h0, 1);
    accept();
    do_start(1, 0);
    send('0, 1'b0);
    check_out("t5_n0", 32'h0, 32'h0, 1);
    accept();
    do_start(1, 40);
    send('0, 1'b0);
    check_out("t5_n40", 32'h0, 32'hFFFF_FFFF, 1);
    accept();

    // Early flush, then stall with a dropped read.
    do_start(4, 8);
    send(sign_vec(32'hFF), 1'b0);
    send(sign_vec(32'hFF), 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_out("t6_flush", 32'hFF, 32'h0, 2);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        llr_valid = 1'b1;
        llr_in    = sign_vec(32'h0);
      end
      if (c == 3) do_start(1, 8);
      else @(negedge clk);
      llr_valid = 1'b0;
    end
    check_out("t6_stall", 32'hFF, 32'h0, 2);
    check("t6_drop", 64'(err_drop), 64'd1);
    accept();
    check("t6_done_valid", 64'(out_valid), 64'd0);
    check("t6_done_busy",  64'(busy), 64'd0);
    check("t6_drop_sticky", 64'(err_drop), 64'd1);

    // Abort in ACCUM restarts the count.
    do_start(2, 8);
    check("t6_drop_clr", 64'(err_drop), 64'd0);
    send(sign_vec(32'hFF), 1'b0);
    do_start(2, 8);
    send(sign_vec(32'h0F), 1'b0);
    check("t6_abort_valid", 64'(out_valid), 64'd0);
    send(sign_vec(32'h0F), 1'b0);
    check_out("t6_abort", 32'h0F, 32'h0, 2);
    accept();

    // Flush together with a read includes that read.
    do_start(4, 8);
    send(sign_vec(32'h3), 1'b0);
    send(sign_vec(32'h3), 1'b1);
    check_out("t7_flush_rd", 32'h3, 32'h0, 2);
    accept();

    // Flush with no reads returns to IDLE silently; bad read counts are ignored.
    do_start(3, 8);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t8_flush0", 64'({busy, out_valid}), 64'd0);
    do_start(0, 8);
    check("t8_nr0_busy", 64'(busy), 64'd0);
    do_start(17, 8);
    check("t8_nr17_busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-cluster.
    do_start(3, 8);
    send(sign_vec(32'hFF), 1'b0);
    rst_n = 1'b0;
    #1;
    check("t9_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t9_rst_idle", 64'({busy, out_valid, err_drop, err_sat}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/llr_read_combiner.md
Name: llr_read_combiner

Overview:
Downstream of the hard-decision decoder container. Accumulates the per-position soft values (±2^23 per bit, negative = bit 1) over several decoded reads of the same DNA strand cluster. Emits one consensus codeword plus an erasure mask once the programmed read count is reached. Output uses a valid/ready handshake toward the outer decoder / host buffer.

Parameters:
DATA_WIDTH, 32, number of bit positions per codeword (matches decoder output array).
LLR_W, 32, width of each incoming signed soft value.
ACC_W, 40, signed accumulator width per position.
MAX_READS, 16, maximum reads per cluster.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin new cluster, latch num_reads_in / N_in
num_reads_in  in  $clog2(MAX_READS+1)  reads to combine (1..MAX_READS)
N_in  in  32 (int)  valid codeword length; positions >= N_in are masked
flush  in  1  pulse: finish cluster early with reads accumulated so far
llr_valid  in  1  one decoded read present on llr_in (driven by decoder calc_done)
llr_in  in  DATA_WIDTH x LLR_W signed  per-position soft values
busy  out  1  high in ACCUM or HOLD
out_valid  out  1  consensus word available
out_ready  in  1  consumer accepts
out_bits  out  DATA_WIDTH  consensus bits (1 = accumulated sum < 0)
out_erasure  out  DATA_WIDTH  1 = accumulated sum == 0 at a valid position
out_reads  out  $clog2(MAX_READS+1)  reads actually combined
err_drop  out  1  sticky: llr_valid arrived in IDLE/HOLD; cleared by accepted start
err_sat  out  1  sticky: any accumulator saturated this cluster; cleared by accepted start

Behaviour:
- Reset: state IDLE; all accumulators, read counter, out_bits, out_erasure, out_reads = 0; out_valid, busy, err_drop, err_sat = 0.
- States: IDLE, ACCUM, HOLD.
- IDLE: start with num_reads_in in 1..MAX_READS -> ACCUM next cycle, latch num_reads and N, clear accumulators, counter, err flags. Start with 0 or > MAX_READS is ignored (stay IDLE). llr_valid in IDLE (including the start cycle) is dropped and sets err_drop.
- ACCUM: each llr_valid cycle: acc[i] += sign-extend(llr_in[i]) for i < N; positions i >= N are held at 0. Counter += 1.
- Saturation: clamp to ±(2^(ACC_W-1)-1). Any clamp sets err_sat.
- ACCUM exit on count: when the counter reaches num_reads, go to HOLD. Latency: out_valid rises on the cycle after the last llr_valid.
- ACCUM flush: with counter >= 1 -> HOLD. With counter == 0 -> IDLE, no output. If flush and llr_valid occur in the same cycle, the read is included before exit.
- ACCUM start (abort): discard the cluster and restart with the new parameters, same rules as IDLE. Any llr_valid in that cycle is dropped.
- HOLD: out_valid = 1.
  - out_bits[i] = acc[i][ACC_W-1] for i < N, else 0.
  - out_erasure[i] = (acc[i] == 0) for i < N, else 0.
  - out_reads = counter.
  - All outputs are stable until out_valid && out_ready, then -> IDLE next cycle with out_valid low.
  - start in HOLD is ignored. llr_valid in HOLD is dropped and sets err_drop.
- N_in >= DATA_WIDTH: all positions valid. N_in <= 0: all positions masked.
- Outputs are registered. rst_n assertion mid-cluster returns immediately to reset values.

Decomposition:
- Package dna_llr_pkg:
  - LLR_ONE = 1<<23
  - state enum {IDLE, ACCUM, HOLD}
  - sat_add function (ACC_W signed add with clamp flag)
  - default widths
- Sub-module llr_sat_acc: one lane holding clear, enable, mask, add with saturation, sat flag. Instantiated DATA_WIDTH times by generate.

Test Plan:
1. start num_reads=3, N=8. Three reads, each with llr_in[i] = -LLR_ONE for even i and +LLR_ONE for odd i -> out_valid one cycle after the 3rd read; out_bits=0x55; erasure=0; out_reads=3.
2. start num_reads=3, N=4. Reads on bit0: -,-,+ ; bit1: +,+,- ; bits2-3 all + -> out_bits=0x1, erasure=0.
3. start num_reads=2, N=4. bit0: +LLR_ONE then -LLR_ONE -> out_erasure=0x1, out_bits bit0=0.
4. LLR_W inputs of +2^31-1, MAX_READS=16, ACC_W=34, num_reads=16 -> acc clamps at 2^33-1; err_sat=1; out_bits=0.
5. N=5, reads with all -LLR_ONE on all 32 positions -> out_bits=0x1F, out_erasure=0 for positions >= 5.
6. Handshake and control:
   - num_reads=4, 2 reads then flush -> out_reads=2.
   - Hold out_ready low 5 cycles with a llr_valid pulse -> outputs stable, err_drop=1.
   - Raise out_ready -> IDLE.
   - start in ACCUM after 1 read -> aborted, new cluster counts from 0.
